// File: rtl/commit_tracer.sv
// Run-control and writeback-trace unit for the multicycle MIPS core: circular commit trace, halt/timeout detection.
// Optional shadow GPR file enabled by defining COMMIT_TRACER_SHADOW_EN.
module commit_tracer #(
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 300,
  parameter int IDLE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_write,
  input  logic [31:0]              pc,
  input  logic                     wb_en,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     pop,
  output logic                     tr_valid,
  output logic [31:0]              tr_pc,
  output logic [4:0]               tr_addr,
  output logic [31:0]              tr_data,
  output logic [$clog2(DEPTH):0]   tr_count,
  output logic                     lost,
  output logic                     done,
  output logic                     timeout,
  output logic [31:0]              cycles,
  input  logic [4:0]               shadow_sel,
  output logic [31:0]              shadow_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_TOUT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  state_t         r_state, w_state_next;
  entry_t         r_mem [DEPTH];
  entry_t         w_head;
  logic [AW-1:0]  r_wp, r_rp;
  logic [CW-1:0]  r_count;
  logic           r_lost;
  logic [31:0]    r_cycles, r_last_pc;
  logic [IW-1:0]  r_idle;

  logic           w_full, w_empty, w_push, w_pop, w_capture_en;
  logic           w_halt_hit, w_tout_hit;
  logic [31:0]    w_pc_cur, w_cycles_next;
  logic [IW-1:0]  w_idle_next;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // The commit that starts the run already traces its own writeback, tagged with the PC it latches.
  assign w_capture_en = (r_state == S_RUN) || ((r_state == S_IDLE) && pc_write);
  assign w_pc_cur     = pc_write ? pc : r_last_pc;
  assign w_push       = w_capture_en && wb_en && (wb_addr != 5'd0);
  assign w_pop        = pop && !w_empty;

  assign w_idle_next   = (pc != r_last_pc)             ? '0     :
                         (r_idle == IW'(IDLE_LIMIT))   ? r_idle : r_idle + 1'b1;
  assign w_cycles_next = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
  assign w_halt_hit    = (r_state == S_RUN) && pc_write && (w_idle_next == IW'(IDLE_LIMIT));
  assign w_tout_hit    = (r_state == S_RUN) && (w_cycles_next == 32'(CYCLE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (pc_write) w_state_next = S_RUN;
      S_RUN: begin
        if (w_halt_hit)      w_state_next = S_HALT;
        else if (w_tout_hit) w_state_next = S_TOUT;
      end
      default: w_state_next = r_state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_lost    <= 1'b0;
      r_cycles  <= '0;
      r_last_pc <= '0;
      r_idle    <= '0;
    end else begin
      if (pc_write) begin
        r_last_pc <= pc;
        r_idle    <= w_idle_next;
      end
      if (r_state == S_RUN) r_cycles <= w_cycles_next;

      if (w_push) begin
        r_wp <= r_wp + 1'b1;
        if (w_pop || w_full) r_rp <= r_rp + 1'b1;
        if (!w_pop && w_full) r_lost <= 1'b1;
        if (!w_pop && !w_full) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // NOTE: trace storage is not reset; the head outputs are gated while empty, so stale entries never show.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= '{pc: w_pc_cur, addr: wb_addr, data: wb_data};
  end

  assign w_head   = r_mem[r_rp];
  assign tr_valid = !w_empty;
  assign tr_pc    = w_empty ? '0 : w_head.pc;
  assign tr_addr  = w_empty ? '0 : w_head.addr;
  assign tr_data  = w_empty ? '0 : w_head.data;
  assign tr_count = r_count;
  assign lost     = r_lost;
  assign done     = (r_state == S_HALT);
  assign timeout  = (r_state == S_TOUT);
  assign cycles   = r_cycles;

`ifdef COMMIT_TRACER_SHADOW_EN
  logic [31:0] r_shadow [32];

  // Shadow is architectural debug state, so unlike the trace array it must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
    end else if (w_push) begin
      r_shadow[wb_addr] <= wb_data;
    end
  end

  assign shadow_data = (shadow_sel == 5'd0) ? '0 : r_shadow[shadow_sel];
`else
  logic w_unused_sel;
  assign w_unused_sel = ^shadow_sel;
  assign shadow_data  = '0;
`endif

endmodule

// File: tb/tb_commit_tracer.sv
// Directed self-checking bench for commit_tracer (default parameters); shadow checks follow COMMIT_TRACER_SHADOW_EN.
module tb_commit_tracer;

  logic        clk = 1'b0;
  logic        rst, pc_write, wb_en, pop;
  logic [31:0] pc, wb_data;
  logic [4:0]  wb_addr, shadow_sel;
  logic        tr_valid, lost, done, timeout;
  logic [31:0] tr_pc, tr_data, cycles, shadow_data;
  logic [4:0]  tr_addr, tr_count;

  int n_tests = 0;
  int n_fail  = 0;

  commit_tracer dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc(pc), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .pop(pop), .tr_valid(tr_valid),
    .tr_pc(tr_pc), .tr_addr(tr_addr), .tr_data(tr_data), .tr_count(tr_count),
    .lost(lost), .done(done), .timeout(timeout), .cycles(cycles),
    .shadow_sel(shadow_sel), .shadow_data(shadow_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic [31:0] pcv, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic pp);
    pc_write = pw; pc = pcv; wb_en = we; wb_addr = wa; wb_data = wd; pop = pp;
    tick();
    pc_write = 1'b0; pc = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_write = 0; pc = 0; wb_en = 0; wb_addr = 0; wb_data = 0; pop = 0;
    shadow_sel = 5'd31;
    do_reset();
    check("rst_valid",   32'(tr_valid), 0);
    check("rst_count",   32'(tr_count), 0);
    check("rst_pc",      tr_pc, 0);
    check("rst_addr",    32'(tr_addr), 0);
    check("rst_data",    tr_data, 0);
    check("rst_lost",    32'(lost), 0);
    check("rst_done",    32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_cycles",  cycles, 0);
    check("rst_shadow",  shadow_data, 0);

    // First commit starts the run and traces its own writeback.
    drive(1, 32'h3000, 1, 5'd1, 32'h1234, 0);
    check("first_state", 32'(dut.r_state), 1);
    check("first_valid", 32'(tr_valid), 1);
    check("first_pc",    tr_pc, 32'h3000);
    check("first_addr",  32'(tr_addr), 1);
    check("first_data",  tr_data, 32'h1234);
    check("first_count", 32'(tr_count), 1);
    check("first_cycles", cycles, 0);

    drive(0, 0, 1, 5'd0, 32'h7, 0);
    drive(0, 0, 1, 5'd2, 32'h5, 0);
    check("r0_skip_count", 32'(tr_count), 2);
    drive(0, 0, 0, 0, 0, 1);
    check("pop1_addr",  32'(tr_addr), 2);
    check("pop1_data",  tr_data, 5);
    check("pop1_pc",    tr_pc, 32'h3000);
    check("pop1_count", 32'(tr_count), 1);
    drive(0, 0, 0, 0, 0, 1);
    check("pop2_valid", 32'(tr_valid), 0);
    check("pop2_data",  tr_data, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("empty_pop_count", 32'(tr_count), 0);
    check("cycles_5",        cycles, 5);

    drive(0, 0, 1, 5'd3, 32'hAA, 1);
    check("empty_pushpop_count", 32'(tr_count), 1);
    check("empty_pushpop_data",  tr_data, 32'hAA);
    drive(0, 0, 0, 0, 0, 1);
    check("drain_valid", 32'(tr_valid), 0);

    for (int i = 1; i <= 16; i++) drive(0, 0, 1, 5'd4, 32'(i), 0);
    check("full_count", 32'(tr_count), 16);
    check("full_lost",  32'(lost), 0);
    check("full_head",  tr_data, 1);
    drive(0, 0, 1, 5'd4, 32'd17, 0);
    check("ovf_count", 32'(tr_count), 16);
    check("ovf_lost",  32'(lost), 1);
    check("ovf_head",  tr_data, 2);
    drive(0, 0, 1, 5'd4, 32'd18, 1);
    check("full_pushpop_count", 32'(tr_count), 16);
    check("full_pushpop_lost",  32'(lost), 1);
    check("full_pushpop_head",  tr_data, 3);

    drive(0, 0, 1, 5'd31, 32'hDEADBEEF, 0);
    check("ovf2_head", tr_data, 4);
`ifdef COMMIT_TRACER_SHADOW_EN
    check("shadow_r31", shadow_data, 32'hDEADBEEF);
    shadow_sel = 5'd0; #1;
    check("shadow_r0", shadow_data, 0);
    shadow_sel = 5'd31;
`else
    check("shadow_off", shadow_data, 0);
`endif

    // One non-matching commit, then IDLE_LIMIT matching ones.
    drive(1, 32'h3040, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) drive(1, 32'h3040, 0, 0, 0, 0);
    check("halt_pre_done", 32'(done), 0);
    drive(1, 32'h3040, 0, 0, 0, 0);
    check("halt_done",    32'(done), 1);
    check("halt_timeout", 32'(timeout), 0);
    check("halt_cycles",  cycles, 35);
    drive(0, 0, 1, 5'd5, 32'h55, 0);
    drive(1, 32'h3044, 0, 0, 0, 0);
    check("halt_nocap_count", 32'(tr_count), 16);
    check("halt_frozen",      cycles, 35);
    check("halt_sticky",      32'(done), 1);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("drain_%0d", i), tr_data, 32'(i + 4));
      drive(0, 0, 0, 0, 0, 1);
    end
    check("drain_last_addr", 32'(tr_addr), 31);
    check("drain_last_data", tr_data, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 1);
    check("drain_empty", 32'(tr_valid), 0);

    // Timeout run with a changing PC.
    do_reset();
    drive(1, 32'h100, 0, 0, 0, 0);
    for (int k = 1; k <= 299; k++) drive(1, 32'h100 + 32'(4 * k), 0, 0, 0, 0);
    check("tout_pre",        32'(timeout), 0);
    check("tout_pre_cycles", cycles, 299);
    drive(1, 32'h100 + 32'd1200, 0, 0, 0, 0);
    check("tout_flag",   32'(timeout), 1);
    check("tout_cycles", cycles, 300);
    check("tout_done",   32'(done), 0);
    drive(0, 0, 0, 0, 0, 0);
    check("tout_frozen", cycles, 300);

    // Halt and timeout on the same clock: halt wins.
    do_reset();
    drive(1, 32'h100, 0, 0, 0, 0);
    for (int k = 1; k <= 299; k++)
      drive(1, (k >= 292) ? 32'h5000 : 32'h100 + 32'(4 * k), 0, 0, 0, 0);
    check("tie_pre_done", 32'(done), 0);
    drive(1, 32'h5000, 0, 0, 0, 0);
    check("tie_done",    32'(done), 1);
    check("tie_timeout", 32'(timeout), 0);
    check("tie_cycles",  cycles, 300);

    // Reset mid-run with active inputs.
    do_reset();
    drive(1, 32'h200, 1, 5'd31, 32'hCAFE, 0);
    drive(0, 0, 1, 5'd6, 32'h1, 0);
    check("mid_count", 32'(tr_count), 2);
`ifdef COMMIT_TRACER_SHADOW_EN
    check("mid_shadow", shadow_data, 32'hCAFE);
`endif
    rst = 1'b1;
    drive(1, 32'h204, 1, 5'd7, 32'h9, 1);
    rst = 1'b0;
    check("mid_rst_valid",  32'(tr_valid), 0);
    check("mid_rst_count",  32'(tr_count), 0);
    check("mid_rst_data",   tr_data, 0);
    check("mid_rst_pc",     tr_pc, 0);
    check("mid_rst_cycles", cycles, 0);
    check("mid_rst_state",  32'(dut.r_state), 0);
    check("mid_rst_shadow", shadow_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
